// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S sample receiver: FSM encoding and sizing helpers.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } rx_state_t;

  localparam int SYNC_DEPTH = 2;

  function automatic int bit_cnt_w(input int slot_max);
    return $clog2(slot_max + 1);
  endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry registered FIFO of {left,right} sample pairs; head entry drives the outputs.
module sample_fifo2 #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_left,
  input  logic [DATA_W-1:0] push_right,
  input  logic              pop,
  output logic [DATA_W-1:0] head_left,
  output logic [DATA_W-1:0] head_right,
  output logic              valid,
  output logic              full
);

  logic              v0_q, v1_q, v0_n, v1_n;
  logic [DATA_W-1:0] l0_q, r0_q, l1_q, r1_q;
  logic [DATA_W-1:0] l0_n, r0_n, l1_n, r1_n;
  logic              pop_ok, push_ok;

  assign pop_ok  = pop & v0_q;
  assign push_ok = push & (~v1_q | pop_ok);

  // Pop shifts the tail forward first, so a push lands in whichever slot is then free.
  always_comb begin
    v0_n = v0_q;
    v1_n = v1_q;
    l0_n = l0_q;
    r0_n = r0_q;
    l1_n = l1_q;
    r1_n = r1_q;
    if (pop_ok) begin
      v0_n = v1_q;
      l0_n = l1_q;
      r0_n = r1_q;
      v1_n = 1'b0;
    end
    if (push_ok) begin
      if (!v0_n) begin
        v0_n = 1'b1;
        l0_n = push_left;
        r0_n = push_right;
      end else begin
        v1_n = 1'b1;
        l1_n = push_left;
        r1_n = push_right;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      l0_q <= '0;
      r0_q <= '0;
    end else begin
      v0_q <= v0_n;
      v1_q <= v1_n;
      l0_q <= l0_n;
      r0_q <= r0_n;
    end
  end

  always_ff @(posedge clk) begin
    l1_q <= l1_n;
    r1_q <= r1_n;
  end

  assign head_left  = l0_q;
  assign head_right = r0_q;
  assign valid      = v0_q;
  assign full       = v1_q;

endmodule

// File: rtl/i2s_sample_rx.sv
// I2S receiver: oversamples s_clk/word_select/serial_data in the aclk domain and
// rebuilds left/right sample pairs into a 2-entry valid/ready buffer.
import i2s_pkg::*;

module i2s_sample_rx #(
  parameter int NUM_BITS_DAC = 24,
  parameter int SLOT_MAX     = 32,
  parameter int CNT_BITS     = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    en,
  input  logic                    s_clk,
  input  logic                    word_select,
  input  logic                    serial_data,
  output logic [NUM_BITS_DAC-1:0] m_left,
  output logic [NUM_BITS_DAC-1:0] m_right,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    overflow,
  input  logic                    ovf_clr,
  output logic [CNT_BITS-1:0]     frame_count
);

  localparam int CW = bit_cnt_w(SLOT_MAX);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CW'(SLOT_MAX)) ? v : v + 1'b1;
  endfunction

  logic [SYNC_DEPTH-1:0] sclk_sync_p1, ws_sync_p1, sd_sync_p1;
  logic                  sclk_p2, edge_p2, ws_p2, sd_p2;
  rx_state_t             state_p3, state_nxt;
  logic                  ws_prev_p3, ws_chg;
  logic [CW-1:0]         cnt_p3;
  logic [NUM_BITS_DAC-1:0] word_p3, word_nxt, left_p3;
  logic [NUM_BITS_DAC-1:0] pair_left_p3, pair_right_p3;
  logic                  push_p3;
  logic                  shift_en, word_clr, left_done, right_done;
  logic                  fifo_full, pop, push_ok, drop;

  // Stage 1: two-flop synchronizers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sclk_sync_p1 <= '0;
      ws_sync_p1   <= '0;
      sd_sync_p1   <= '0;
    end else begin
      sclk_sync_p1 <= {sclk_sync_p1[SYNC_DEPTH-2:0], s_clk};
      ws_sync_p1   <= {ws_sync_p1[SYNC_DEPTH-2:0], word_select};
      sd_sync_p1   <= {sd_sync_p1[SYNC_DEPTH-2:0], serial_data};
    end
  end

  // Stage 2: bit-edge detect, with ws/sd captured alongside
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sclk_p2 <= 1'b0;
      edge_p2 <= 1'b0;
      ws_p2   <= 1'b0;
      sd_p2   <= 1'b0;
    end else begin
      sclk_p2 <= sclk_sync_p1[SYNC_DEPTH-1];
      edge_p2 <= sclk_sync_p1[SYNC_DEPTH-1] & ~sclk_p2;
      ws_p2   <= ws_sync_p1[SYNC_DEPTH-1];
      sd_p2   <= sd_sync_p1[SYNC_DEPTH-1];
    end
  end

  assign ws_chg = edge_p2 & (ws_p2 != ws_prev_p3);

  always_comb begin
    state_nxt  = state_p3;
    shift_en   = 1'b0;
    word_clr   = 1'b0;
    left_done  = 1'b0;
    right_done = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state_p3)
        IDLE: state_nxt = SYNC;
        SYNC: begin
          if (ws_chg && !ws_p2) begin
            word_clr  = 1'b1;
            state_nxt = LEFT;
          end
        end
        LEFT: begin
          if (ws_chg && ws_p2) begin
            left_done = 1'b1;
            state_nxt = RIGHT;
          end else if (edge_p2) begin
            shift_en = 1'b1;
          end
        end
        RIGHT: begin
          if (ws_chg && !ws_p2) begin
            right_done = 1'b1;
            state_nxt  = LEFT;
          end else if (edge_p2) begin
            shift_en = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bit k of the slot lands at position MSB-k; bits past the word width fall off.
  always_comb begin
    word_nxt = word_p3;
    for (int i = 0; i < NUM_BITS_DAC; i++) begin
      if (cnt_p3 == CW'(NUM_BITS_DAC - 1 - i)) word_nxt[i] = sd_p2;
    end
  end

  // Stage 3: framing FSM and word assembly
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_p3   <= IDLE;
      ws_prev_p3 <= 1'b0;
      cnt_p3     <= '0;
      push_p3    <= 1'b0;
    end else begin
      state_p3 <= state_nxt;
      push_p3  <= right_done;
      if (edge_p2) ws_prev_p3 <= ws_p2;
      if (word_clr || left_done || right_done) cnt_p3 <= '0;
      else if (shift_en) cnt_p3 <= sat_inc(cnt_p3);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (word_clr || left_done || right_done) word_p3 <= '0;
    else if (shift_en) word_p3 <= word_nxt;
    if (left_done) left_p3 <= word_nxt;
    if (right_done) begin
      pair_left_p3  <= left_p3;
      pair_right_p3 <= word_nxt;
    end
  end

  // Stage 4: buffer write, drop accounting
  assign pop     = m_valid & m_ready;
  assign push_ok = push_p3 & (~fifo_full | pop);
  assign drop    = push_p3 & fifo_full & ~pop;

  sample_fifo2 #(
    .DATA_W(NUM_BITS_DAC)
  ) u_fifo (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .push      (push_ok),
    .push_left (pair_left_p3),
    .push_right(pair_right_p3),
    .pop       (pop),
    .head_left (m_left),
    .head_right(m_right),
    .valid     (m_valid),
    .full      (fifo_full)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (push_ok) frame_count <= frame_count + 1'b1;
    end
  end

endmodule
